// File: rtl/inst_fetch_buffer_pkg.sv
// Shared CPU fetch-path types and constants.
// Pure declarations, no timing.
// No flow control here; consumers define handshakes.
package inst_fetch_buffer_pkg;

    // Instruction word presented to decode when nothing is buffered.
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    // The fetch buffer is built around exactly two entries.
    localparam int IFB_DEPTH = 2;

    // One buffered fetch: the address and the word read from it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer.sv
// Two-entry fetch-to-decode FIFO of {pc, inst} pairs.
// Latency: 1 cycle from push edge to dec_* outputs, no bypass.
// Backpressure: fetch_ready/hold_pc from registered count only; flush wins over push and pop.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT,
    parameter int          DEPTH    = IFB_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_inst,
    output logic        fetch_ready,
    output logic        hold_pc,
    input  logic        flush,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc4,
    output logic [1:0]  count
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;
    fetch_entry_t head;

    // Handshakes: ready/valid come from registered count, so no input reaches them combinationally.
    always_comb begin
        fetch_ready = (count != FULL_COUNT);
        hold_pc     = !fetch_ready;
        dec_valid   = (count != 2'd0);
        push        = fetch_valid && fetch_ready && !flush;
        pop         = dec_valid && dec_ready && !flush;
    end

    // Decode-side view of the head entry; an empty buffer shows a NOP at pc 0.
    always_comb begin
        head     = mem[rd_ptr];
        dec_inst = NOP_INST;
        dec_pc   = 32'h0;
        if (dec_valid) begin
            dec_inst = head.inst;
            dec_pc   = head.pc;
        end
        dec_pc4 = dec_pc + 32'd4;
    end

    // Storage, pointers and occupancy; flush discards everything, data in that cycle included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: pc_in, inst: fetch_inst};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: queue scoreboard driven each cycle, compared on every pop.
// Inputs driven and outputs sampled on the falling edge.
// Source stalls are modelled by the bench dropping fetches offered while full.
module tb_inst_fetch_buffer;
    import inst_fetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = '0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_inst = '0;
    logic        fetch_ready;
    logic        hold_pc;
    logic        flush = 1'b0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc4;
    logic [1:0]  count;

    int n_checks = 0;
    int n_errs   = 0;

    fetch_entry_t sb[$];

    inst_fetch_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_ready (fetch_ready),
        .hold_pc     (hold_pc),
        .flush       (flush),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .dec_pc4     (dec_pc4),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Flags and empty-buffer outputs against the scoreboard occupancy.
    task automatic chk_state();
        chk("count", 32'(count), 32'(sb.size()));
        chk("fetch_ready", 32'(fetch_ready), 32'(sb.size() != 2));
        chk("hold_pc", 32'(hold_pc), 32'(sb.size() == 2));
        chk("dec_valid", 32'(dec_valid), 32'(sb.size() != 0));
        if (sb.size() == 0) begin
            chk("empty_inst", dec_inst, 32'h0);
            chk("empty_pc", dec_pc, 32'h0);
            chk("empty_pc4", dec_pc4, 32'h4);
        end else begin
            chk("head_pc4", dec_pc4, sb[0].pc + 32'd4);
        end
    endtask

    // One cycle: starts and ends on a falling edge.
    task automatic cyc(input logic fv, input logic [31:0] pc, input logic dr, input logic fl);
        fetch_entry_t e;
        bit do_pop;
        bit do_push;
        fetch_valid = fv;
        pc_in       = pc;
        fetch_inst  = inst_of(pc);
        dec_ready   = dr;
        flush       = fl;
        #1;
        chk_state();
        do_pop  = !fl && dr && (sb.size() != 0);
        do_push = !fl && fv && (sb.size() < 2);
        if (do_pop) begin
            e = sb.pop_front();
            chk("pop_pc", dec_pc, e.pc);
            chk("pop_inst", dec_inst, e.inst);
        end
        if (fl) sb.delete();
        if (do_push) sb.push_back('{pc: pc, inst: inst_of(pc)});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state, held over a few edges.
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_dec_inst", dec_inst, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_pc4", dec_pc4, 32'h4);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'h1);
        chk("rst_hold_pc", 32'(hold_pc), 32'h0);
        rst_n = 1'b1;

        // Fill and stall; the third fetch is refused.
        cyc(1'b1, 32'h0040_0000, 1'b0, 1'b0);
        chk("first_push_visible", dec_pc, 32'h0040_0000);
        cyc(1'b1, 32'h0040_0004, 1'b0, 1'b0);
        chk("full_hold_pc", 32'(hold_pc), 32'h1);
        cyc(1'b1, 32'h0040_0008, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ready_after_pop", 32'(fetch_ready), 32'h1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        // Empty: dec_ready must not underflow.
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming at occupancy 1.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'h0040_0000 + 32'(4 * i), 1'b1, 1'b0);
            chk("stream_lag", dec_pc, 32'h0040_0000 + 32'(4 * i));
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while full, with a push and pop offered in the same cycle.
        cyc(1'b1, 32'h0050_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h0050_0004, 1'b0, 1'b0);
        cyc(1'b1, 32'h0050_0008, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_dec_valid", 32'(dec_valid), 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Pointer wrap with interleaved pops.
        cyc(1'b1, 32'h0060_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h0060_0004, 1'b1, 1'b0);
        cyc(1'b1, 32'h0060_0008, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h0060_000C, 1'b1, 1'b0);
        cyc(1'b1, 32'h0060_0010, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // dec_pc4 wraps at the top of the address space.
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        chk("pc4_wrap", dec_pc4, 32'h0000_0000);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Mid-stream reset while full clears outputs immediately.
        cyc(1'b1, 32'h0070_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h0070_0004, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("mid_rst_dec_inst", dec_inst, 32'h0);
        chk("mid_rst_fetch_ready", 32'(fetch_ready), 32'h1);
        sb.delete();
        fetch_valid = 1'b0;
        dec_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h0080_0000, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0000, is the instruction word driven on dec_inst while the buffer is empty.
REQ-002 Parameter DEPTH, default 2, is the entry count; only DEPTH=2 is supported.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pc_in  input  32  fetch address from the PC register, paired with fetch_inst.
REQ-006 fetch_valid  input  1  instruction memory has fetch_inst/pc_in ready this cycle.
REQ-007 fetch_inst  input  32  instruction word read at pc_in.
REQ-008 fetch_ready  output  1  buffer accepts a push this cycle.
REQ-009 hold_pc  output  1  stall to the PC: must not advance; equals !fetch_ready.
REQ-010 flush  input  1  branch/jump redirect: discard all buffered entries.
REQ-011 dec_valid  output  1  head entry presented to decode.
REQ-012 dec_ready  input  1  decode accepts the head entry this cycle.
REQ-013 dec_inst  output  32  head instruction, or NOP_INST when empty.
REQ-014 dec_pc  output  32  head entry's pc_in value, or 0 when empty.
REQ-015 dec_pc4  output  32  dec_pc + 4, modulo 2^32.
REQ-016 count  output  2  current occupancy, 0..2.

Function
REQ-017 The block shall be a 2-entry FIFO of {pc, inst} pairs with 1-bit write and read pointers that wrap 1->0.
REQ-018 Push shall occur when fetch_valid && fetch_ready && !flush.
REQ-019 Pop shall occur when dec_valid && dec_ready && !flush.
REQ-020 fetch_ready shall be (count != 2), derived from registered state only, with no combinational path from dec_ready or fetch_valid.
REQ-021 dec_valid shall be (count != 0), with dec_inst/dec_pc driven from the read-pointer entry.
REQ-022 Latency shall be 1 cycle: a pushed entry appears on the dec_* outputs in the cycle after the push edge, with no same-cycle bypass.
REQ-023 With simultaneous push and pop at count 1, count shall stay 1 and the pushed entry shall become the head.
REQ-024 At count 2 there shall be no push, and a pop shall take count to 1, so fetch_ready rises the next cycle.
REQ-025 At count 0, dec_ready shall be ignored, with no underflow.
REQ-026 fetch_valid while fetch_ready=0 shall be ignored; the source must hold via hold_pc.
REQ-027 flush shall be synchronous with priority over push and pop: next count=0, both pointers=0, and that cycle's fetch data is dropped.
REQ-028 dec_pc4 shall wrap: dec_pc 32'hFFFF_FFFC yields 32'h0000_0000.
REQ-029 Entries shall never be reordered or duplicated; pop order equals push order.

Reset
REQ-030 Assertion of rst_n=0 shall immediately clear count, both pointers and all entry storage to 0, regardless of any in-flight push or pop.
REQ-031 During and after reset, outputs shall be: dec_valid=0, dec_inst=NOP_INST, dec_pc=0, dec_pc4=4, fetch_ready=1, hold_pc=0, count=0.
REQ-032 Reset deassertion shall be the only exit; the first push is accepted on the first rising edge after deassertion.

Structure
REQ-033 NOP_INST default, the DEPTH constant and the fetch-entry struct {pc[31:0], inst[31:0]} shall reside in the shared CPU package.
REQ-034 No sub-module is required; the storage array, pointers and count live in inst_fetch_buffer.

Verification
REQ-035 Reset: hold rst_n=0 mid-stream with count=2 -> count=0, dec_valid=0, dec_inst=32'h0, fetch_ready=1 immediately.
REQ-036 Fill and stall: push pc 0x00400000/0x00400004 with dec_ready=0 -> count=2, hold_pc=1, and a third fetch_valid is ignored; after one pop, fetch_ready=1 next cycle.
REQ-037 Stream: fetch_valid=1 and dec_ready=1 every cycle, pc stepping by 4 from 0x00400000 -> dec_pc lags pc_in by 1 cycle, count holds 1, in-order.
REQ-038 Flush priority: count=2 with flush=1, fetch_valid=1 and dec_ready=1 in the same cycle -> next cycle count=0, dec_valid=0, no entry from that cycle survives.
REQ-039 Wrap: push 5 entries with interleaved pops across pointer wrap -> pop order matches push order; pc 0xFFFFFFFC gives dec_pc4=0x00000000.
